pulse_window_counter: RTL
=========================

# pulse_window_counter

Measurement front end that feeds the seven-segment display path. It counts rising edges of an external pulse input during a fixed gate window of `clk` cycles. At the end of each window it publishes the result on `validCount`, a stable, saturated count held until the next window closes, together with a one-cycle `validStrobe`. Downstream display logic samples `validCount` at any time and always sees a complete, settled measurement.

## Interface
- `WIDTH`, 7: width of `validCount` and the internal edge counter.
- `GATE_CYCLES`, 1000: length of the counting window in `clk` cycles; must be ≥ 2.
- `HOLD_CYCLES`, 2: dead time between windows in `clk` cycles; edges are ignored during it; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-high; the one clock and this reset are the only timing inputs.
- `enable`  in  1: synchronous run request; measurements start and continue only while it is high.
- `pulseIn`  in  1: external pulse train, asynchronous to `clk`.
- `validCount`  out  WIDTH: last completed measurement.
- `validStrobe`  out  1: high for exactly one cycle when `validCount` is updated.
- `overflow`  out  1: high when the last completed window saturated; updated together with `validCount`.

## Operation
- Input path:
  - `pulseIn` passes through a 2-flop synchronizer, then an edge-detect flop.
  - `edge` = synchronized value high AND previous synchronized value low.
  - A pulse must be high for ≥ 1 full cycle and low for ≥ 1 full cycle to be counted once.
- State machine states: IDLE, GATE, HOLD.
  - IDLE: counter and timer are held at 0. `enable`=1 moves to GATE on the next edge.
  - GATE: timer counts 0..GATE_CYCLES-1. Each cycle with `edge`=1 increments the counter.
    - On the timer = GATE_CYCLES-1 cycle, `validCount` is loaded with sat(count + edge), where the edge of that same final cycle is included.
    - On the same cycle, `overflow` is loaded with (count + edge > 2^WIDTH-1), `validStrobe` is set, the counter and timer clear, and the FSM moves to HOLD.
  - HOLD: lasts HOLD_CYCLES cycles with the counter held at 0 and edges discarded.
    - At the end of HOLD: `enable`=1 moves to GATE, otherwise to IDLE.
  - `enable` falling during GATE aborts the window: go to IDLE next cycle, discard the partial count, no strobe, and leave `validCount`/`overflow` unchanged.
  - `enable` falling during HOLD takes effect at the end of HOLD.
- Arithmetic: the counter is WIDTH bits and saturates at 2^WIDTH-1; it never wraps. A sticky saturation bit per window drives `overflow`.
- Reset, at any time including mid-window:
  - FSM goes to IDLE; counter, timer, synchronizer and edge flops are cleared.
  - `validCount` = 0, `validStrobe` = 0, `overflow` = 0.
  - A partially counted window is lost.

## Timing
- `pulseIn` rise to `edge` asserted: 3 `clk` edges (2 sync flops plus 1 edge flop). Edges arriving within the last ~3 cycles of a window therefore count in the following window, or are lost if they land in HOLD.
- Window period: GATE_CYCLES + HOLD_CYCLES cycles.
- `validCount`, `overflow` and `validStrobe` change on the clock edge that ends the final GATE cycle, so they are visible during the first HOLD cycle. `validStrobe` is high for that one cycle only.
- First result after `enable` rises from IDLE: 1 + GATE_CYCLES cycles.
- `validCount` is glitch-free: it is a registered output that changes only at the strobe edge.

## Test plan
- Reset: assert `reset` asynchronously mid-GATE with count = 5 → all outputs are 0 within the same cycle; after release with `enable`=0 the FSM stays in IDLE and no strobe appears.
- Nominal (WIDTH=4, GATE=20, HOLD=2): a 2-cycle-high/2-cycle-low pulse train with `enable` held high → every window yields `validCount` = 5, `overflow` = 0, strobe period 22 cycles.
- Saturation (WIDTH=3, GATE=20): a 1-high/1-low pulse train gives 10 edges → `validCount` = 7, `overflow` = 1. Next window at 3 edges → `validCount` = 3, `overflow` = 0.
- Boundary edges: one edge detected on the last GATE cycle is counted; one edge detected in the first HOLD cycle is not counted → `validCount` = 1.
- Abort: drop `enable` at GATE timer = 10 with count = 3 → no strobe, `validCount` keeps its previous value (e.g. 5), FSM returns to IDLE. Re-enable → a full fresh window, first strobe after 21 cycles.
- Zero input: `pulseIn` held high throughout → `validCount` = 0 every window and strobes keep occurring.

Source files
------------

// File: rtl/pulse_window_counter.sv
// Gated edge counter: counts synchronized rising edges of pulseIn over a fixed
// window of clk cycles and publishes a saturated, held result with a one-cycle strobe.
module pulse_window_counter #(
  parameter int WIDTH       = 7,
  parameter int GATE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulseIn,
  output logic [WIDTH-1:0] validCount,
  output logic             validStrobe,
  output logic             overflow
);

  localparam int TMAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_validCount;
  logic             r_sat;
  logic             r_strobe;
  logic             r_overflow;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_edge;

  logic [WIDTH:0]   w_sum;
  logic             w_final_ovf;
  logic [WIDTH-1:0] w_final_val;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= pulseIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  // Final-cycle result folds in the edge seen on that same cycle.
  always_comb begin
    w_sum       = {1'b0, r_count} + {{WIDTH{1'b0}}, r_edge};
    w_final_ovf = r_sat | w_sum[WIDTH];
    w_final_val = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_count      <= '0;
      r_sat        <= 1'b0;
      r_validCount <= '0;
      r_overflow   <= 1'b0;
      r_strobe     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          r_count <= '0;
          r_sat   <= 1'b0;
          if (enable) r_state <= S_GATE;
        end
        S_GATE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
          end else if (r_timer == GATE_LAST) begin
            r_validCount <= w_final_val;
            r_overflow   <= w_final_ovf;
            r_strobe     <= 1'b1;
            r_timer      <= '0;
            r_count      <= '0;
            r_sat        <= 1'b0;
            r_state      <= S_HOLD;
          end else begin
            r_timer <= r_timer + TW'(1);
            if (r_edge) begin
              if (r_count == '1) r_sat <= 1'b1;
              else               r_count <= r_count + WIDTH'(1);
            end
          end
        end
        S_HOLD: begin
          r_count <= '0;
          if (r_timer == HOLD_LAST) begin
            r_timer <= '0;
            r_state <= enable ? S_GATE : S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_count <= '0;
          r_sat   <= 1'b0;
        end
      endcase
    end
  end

  assign validCount  = r_validCount;
  assign validStrobe = r_strobe;
  assign overflow    = r_overflow;

endmodule
